// File: rtl/rf_port_sequencer_if.sv
// Bus bundle between the control unit / compute units and the register-file port sequencer.
// The sequencer takes the slave view; the stimulus side takes the master view.
interface rf_port_sequencer_if #(
    parameter int NUM_PU = 2,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 128,
    parameter int SEL_W  = 3
);
    logic [ADDR_W-1:0]        in_cu_address;
    logic [WIDTH-1:0]         in_cu_data;
    logic [1:0]               in_cu_type;
    logic [1:0]               in_cu_matrix;
    logic                     in_cu_read_en;
    logic                     in_cu_write_en;
    logic                     in_cu_start;
    logic [SEL_W-1:0]         in_cu_pu_sel;
    logic                     in_cu_clear;
    logic [NUM_PU*ADDR_W-1:0] in_pu_address;
    logic [NUM_PU*WIDTH-1:0]  in_pu_data;
    logic [NUM_PU*2-1:0]      in_pu_type;
    logic [NUM_PU*2-1:0]      in_pu_matrix;
    logic [NUM_PU-1:0]        in_pu_read_en;
    logic [NUM_PU-1:0]        in_pu_write_en;
    logic [NUM_PU-1:0]        in_pu_done;
    logic [ADDR_W-1:0]        out_rf_address;
    logic [WIDTH-1:0]         out_rf_data;
    logic [1:0]               out_rf_type;
    logic [1:0]               out_rf_matrix;
    logic                     out_rf_read_en;
    logic                     out_rf_write_en;
    logic                     out_rf_clear;
    logic [NUM_PU-1:0]        out_pu_start;
    logic [NUM_PU-1:0]        out_pu_data_ready;
    logic                     out_pu_done_ack;
    logic [SEL_W:0]           out_owner;
    logic                     out_sel_error;

    modport master (
        output in_cu_address, in_cu_data, in_cu_type, in_cu_matrix, in_cu_read_en,
               in_cu_write_en, in_cu_start, in_cu_pu_sel, in_cu_clear,
               in_pu_address, in_pu_data, in_pu_type, in_pu_matrix, in_pu_read_en,
               in_pu_write_en, in_pu_done,
        input  out_rf_address, out_rf_data, out_rf_type, out_rf_matrix, out_rf_read_en,
               out_rf_write_en, out_rf_clear, out_pu_start, out_pu_data_ready,
               out_pu_done_ack, out_owner, out_sel_error
    );

    modport slave (
        input  in_cu_address, in_cu_data, in_cu_type, in_cu_matrix, in_cu_read_en,
               in_cu_write_en, in_cu_start, in_cu_pu_sel, in_cu_clear,
               in_pu_address, in_pu_data, in_pu_type, in_pu_matrix, in_pu_read_en,
               in_pu_write_en, in_pu_done,
        output out_rf_address, out_rf_data, out_rf_type, out_rf_matrix, out_rf_read_en,
               out_rf_write_en, out_rf_clear, out_pu_start, out_pu_data_ready,
               out_pu_done_ack, out_owner, out_sel_error
    );
endinterface

// File: rtl/rf_port_sequencer.sv
// Register-file port sequencer: hands RF port ownership between the CU and one PU,
// registers RF command fields, tracks reads for data-ready strobes and drains before handback.
module rf_port_sequencer #(
    parameter int NUM_PU = 2,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 128,
    parameter int RD_LAT = 1,
    parameter int SEL_W  = 3
) (
    input logic              in_clk,
    input logic              in_reset,
    rf_port_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_CU    = 2'd0,
        S_PU    = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Tag layout: [TAG_W-1] valid, [SEL_W] owner-is-PU, [SEL_W-1:0] PU index.
    localparam int TAG_W = SEL_W + 2;

    state_e              state_q;
    logic [ADDR_W-1:0]   rf_address_q, rf_address_d;
    logic [WIDTH-1:0]    rf_data_q, rf_data_d;
    logic [1:0]          rf_type_q, rf_type_d;
    logic [1:0]          rf_matrix_q, rf_matrix_d;
    logic                rf_read_en_q, rf_read_en_d;
    logic                rf_write_en_q, rf_write_en_d;
    logic                rf_clear_q;
    logic                post_reset_q;
    logic [NUM_PU-1:0]   pu_start_q, pu_start_d;
    logic [NUM_PU-1:0]   data_ready_q, data_ready_d;
    logic                done_ack_q;
    logic [SEL_W:0]      owner_q;
    logic                sel_error_q;
    logic [TAG_W-1:0]    tag_q [RD_LAT];

    logic [NUM_PU-1:0]   own_sel_d;
    logic [ADDR_W-1:0]   own_address_d;
    logic [WIDTH-1:0]    own_data_d;
    logic [1:0]          own_type_d;
    logic [1:0]          own_matrix_d;
    logic                own_read_d;
    logic                own_write_d;
    logic                own_done_d;
    logic                sel_ok_d;
    logic                pending_d;
    logic [SEL_W:0]      src_d;

    // Owner field mux, start/data-ready decode and next RF command fields.
    always_comb begin
        own_sel_d     = {NUM_PU{1'b0}};
        pu_start_d    = {NUM_PU{1'b0}};
        data_ready_d  = {NUM_PU{1'b0}};
        own_address_d = {ADDR_W{1'b0}};
        own_data_d    = {WIDTH{1'b0}};
        own_type_d    = 2'b00;
        own_matrix_d  = 2'b00;
        own_read_d    = 1'b0;
        own_write_d   = 1'b0;
        pending_d     = 1'b0;
        for (int i = 0; i < NUM_PU; i++) begin
            own_sel_d[i]    = (owner_q[SEL_W-1:0] == SEL_W'(i));
            pu_start_d[i]   = (bus.in_cu_pu_sel == SEL_W'(i));
            data_ready_d[i] = tag_q[RD_LAT-1][TAG_W-1] & tag_q[RD_LAT-1][SEL_W]
                              & (tag_q[RD_LAT-1][SEL_W-1:0] == SEL_W'(i));
        end
        for (int i = 0; i < NUM_PU; i++) begin
            own_address_d = own_address_d | ({ADDR_W{own_sel_d[i]}} & bus.in_pu_address[i*ADDR_W +: ADDR_W]);
            own_data_d    = own_data_d    | ({WIDTH{own_sel_d[i]}}  & bus.in_pu_data[i*WIDTH +: WIDTH]);
            own_type_d    = own_type_d    | ({2{own_sel_d[i]}}      & bus.in_pu_type[i*2 +: 2]);
            own_matrix_d  = own_matrix_d  | ({2{own_sel_d[i]}}      & bus.in_pu_matrix[i*2 +: 2]);
            own_read_d    = own_read_d    | (own_sel_d[i] & bus.in_pu_read_en[i]);
            own_write_d   = own_write_d   | (own_sel_d[i] & bus.in_pu_write_en[i]);
        end
        for (int i = 0; i < RD_LAT; i++) begin
            pending_d = pending_d | tag_q[i][TAG_W-1];
        end
        own_done_d = |(own_sel_d & bus.in_pu_done);
        sel_ok_d   = (32'(bus.in_cu_pu_sel) < 32'(NUM_PU));
        // CU reads issued in the handoff cycle are tagged as CU reads, not as the new owner's.
        src_d      = (state_q == S_PU) ? owner_q : {(SEL_W+1){1'b0}};

        rf_address_d  = rf_address_q;
        rf_data_d     = rf_data_q;
        rf_type_d     = rf_type_q;
        rf_matrix_d   = rf_matrix_q;
        rf_read_en_d  = 1'b0;
        rf_write_en_d = 1'b0;
        case (state_q)
            S_CU: begin
                rf_address_d  = bus.in_cu_address;
                rf_data_d     = bus.in_cu_data;
                rf_type_d     = bus.in_cu_type;
                rf_matrix_d   = bus.in_cu_matrix;
                rf_read_en_d  = bus.in_cu_read_en;
                rf_write_en_d = bus.in_cu_write_en;
            end
            S_PU: begin
                rf_address_d  = own_address_d;
                rf_data_d     = own_data_d;
                rf_type_d     = own_type_d;
                rf_matrix_d   = own_matrix_d;
                rf_read_en_d  = own_read_d;
                rf_write_en_d = own_write_d;
            end
            default: begin
                rf_read_en_d  = 1'b0;
                rf_write_en_d = 1'b0;
            end
        endcase
    end

    // Ownership FSM, registered outputs and read-tag pipeline.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q       <= S_CU;
            rf_address_q  <= {ADDR_W{1'b0}};
            rf_data_q     <= {WIDTH{1'b0}};
            rf_type_q     <= 2'b00;
            rf_matrix_q   <= 2'b00;
            rf_read_en_q  <= 1'b0;
            rf_write_en_q <= 1'b0;
            rf_clear_q    <= 1'b1;
            post_reset_q  <= 1'b1;
            pu_start_q    <= {NUM_PU{1'b0}};
            data_ready_q  <= {NUM_PU{1'b0}};
            done_ack_q    <= 1'b0;
            owner_q       <= {(SEL_W+1){1'b0}};
            sel_error_q   <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= {TAG_W{1'b0}};
            end
        end else begin
            rf_address_q  <= rf_address_d;
            rf_data_q     <= rf_data_d;
            rf_type_q     <= rf_type_d;
            rf_matrix_q   <= rf_matrix_d;
            rf_read_en_q  <= rf_read_en_d;
            rf_write_en_q <= rf_write_en_d;
            rf_clear_q    <= post_reset_q | (bus.in_cu_clear & (state_q == S_CU));
            post_reset_q  <= 1'b0;
            pu_start_q    <= {NUM_PU{1'b0}};
            done_ack_q    <= 1'b0;
            data_ready_q  <= data_ready_d;
            tag_q[0]      <= {rf_read_en_d, src_d};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            case (state_q)
                S_CU: begin
                    if (bus.in_cu_start && sel_ok_d) begin
                        state_q    <= S_PU;
                        owner_q    <= {1'b1, bus.in_cu_pu_sel};
                        pu_start_q <= pu_start_d;
                    end else if (bus.in_cu_start) begin
                        sel_error_q <= 1'b1;
                    end else begin
                        state_q <= S_CU;
                    end
                end
                S_PU: begin
                    if (own_done_d) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_PU;
                    end
                end
                S_DRAIN: begin
                    if (!pending_d) begin
                        state_q    <= S_CU;
                        done_ack_q <= 1'b1;
                        owner_q    <= {(SEL_W+1){1'b0}};
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    state_q <= S_CU;
                    owner_q <= {(SEL_W+1){1'b0}};
                end
            endcase
        end
    end

    assign bus.out_rf_address    = rf_address_q;
    assign bus.out_rf_data       = rf_data_q;
    assign bus.out_rf_type       = rf_type_q;
    assign bus.out_rf_matrix     = rf_matrix_q;
    assign bus.out_rf_read_en    = rf_read_en_q;
    assign bus.out_rf_write_en   = rf_write_en_q;
    assign bus.out_rf_clear      = rf_clear_q;
    assign bus.out_pu_start      = pu_start_q;
    assign bus.out_pu_data_ready = data_ready_q;
    assign bus.out_pu_done_ack   = done_ack_q;
    assign bus.out_owner         = owner_q;
    assign bus.out_sel_error     = sel_error_q;
endmodule
